mac_sat_pipe: RTL

//  Parametrised, pipelined signed multiply-accumulate with saturating accumulator.

---
 rtl/mac_pkg.sv | 32 +++
 rtl/mac_mult_pipe.sv | 48 ++++
 rtl/mac_sat_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared helpers for the saturating MAC: accumulator bound arithmetic and the saturation decision.
package mac_pkg;

  localparam int MAX_W = 64;

  typedef logic signed [MAX_W:0] wide_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_MAX  = 2'd1,
    SAT_MIN  = 2'd2
  } sat_kind_t;

  function automatic wide_t acc_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Classifies a sum carried at WIDTH_ACC+1 bits against the w-bit signed range.
  function automatic sat_kind_t saturate(input wide_t sum, input int w);
    if (sum > acc_max(w)) begin
      return SAT_MAX;
    end else if (sum < acc_min(w)) begin
      return SAT_MIN;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed full-width multiplier followed by PIPE register stages; valid travels alongside the product.
module mac_mult_pipe #(
  parameter int WIDTH_IN = 12,
  parameter int PIPE     = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [WIDTH_IN-1:0]     a,
  input  logic signed [WIDTH_IN-1:0]     b,
  input  logic                           valid_in,
  output logic signed [2*WIDTH_IN-1:0]   prod,
  output logic                           valid_out
);

  logic signed [2*WIDTH_IN-1:0] prod_c;

  assign prod_c = a * b;

  generate
    if (PIPE == 0) begin : g_comb
      assign prod      = prod_c;
      assign valid_out = valid_in;
    end else begin : g_pipe
      logic signed [2*WIDTH_IN-1:0] prod_q [PIPE];
      logic        [PIPE-1:0]       vld_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < PIPE; i++) begin
            prod_q[i] <= '0;
          end
        end else begin
          prod_q[0] <= prod_c;
          vld_q[0]  <= valid_in;
          for (int i = 1; i < PIPE; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
        end
      end

      assign prod      = prod_q[PIPE-1];
      assign valid_out = vld_q[PIPE-1];
    end
  endgenerate

endmodule

// File: rtl/mac_sat_pipe.sv
// Pipelined signed MAC with saturating accumulator, optional fixed-length blocks and sticky saturation flag.
module mac_sat_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_ACC = 24,
  parameter int PIPE      = 0,
  parameter int ACC_LEN   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [WIDTH_IN-1:0]   a,
  input  logic signed [WIDTH_IN-1:0]   b,
  input  logic                         valid_in,
  input  logic                         clear,
  output logic signed [WIDTH_ACC-1:0]  f,
  output logic                         valid_out,
  output logic                         sat_flag,
  output logic                         done
);

  localparam int CW = (ACC_LEN > 0) ? $clog2(ACC_LEN + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((ACC_LEN > 0) ? ACC_LEN - 1 : 0);
  localparam logic signed [WIDTH_ACC-1:0] ACC_MAX = WIDTH_ACC'(acc_max(WIDTH_ACC));
  localparam logic signed [WIDTH_ACC-1:0] ACC_MIN = WIDTH_ACC'(acc_min(WIDTH_ACC));

  logic signed [WIDTH_IN-1:0]    a_q;
  logic signed [WIDTH_IN-1:0]    b_q;
  logic                          vld_q;
  logic signed [2*WIDTH_IN-1:0]  prod;
  logic                          prod_vld;
  logic [CW-1:0]                 count;
  logic [CW-1:0]                 cnt_base;
  logic                          fresh;
  logic signed [WIDTH_ACC-1:0]   base;
  logic signed [WIDTH_ACC:0]     sum;
  sat_kind_t                     kind;
  logic signed [WIDTH_ACC-1:0]   acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      vld_q <= valid_in;
    end
  end

  mac_mult_pipe #(
    .WIDTH_IN (WIDTH_IN),
    .PIPE     (PIPE)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .a         (a_q),
    .b         (b_q),
    .valid_in  (vld_q),
    .prod      (prod),
    .valid_out (prod_vld)
  );

  // A sample starts from zero after a clear or at the head of a new block.
  always_comb begin
    fresh    = clear || ((ACC_LEN > 0) && (count == '0));
    cnt_base = clear ? '0 : count;
    base     = fresh ? '0 : f;
    sum      = (WIDTH_ACC+1)'(base) + (WIDTH_ACC+1)'(prod);
    kind     = saturate(wide_t'(sum), WIDTH_ACC);
    case (kind)
      SAT_MAX: acc_nxt = ACC_MAX;
      SAT_MIN: acc_nxt = ACC_MIN;
      default: acc_nxt = sum[WIDTH_ACC-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      valid_out <= prod_vld;
      done      <= 1'b0;
      if (prod_vld) begin
        f        <= acc_nxt;
        sat_flag <= (fresh ? 1'b0 : sat_flag) | (kind != SAT_NONE);
        if (ACC_LEN > 0) begin
          if (cnt_base == LAST) begin
            count <= '0;
            done  <= 1'b1;
          end else begin
            count <= cnt_base + 1'b1;
          end
        end
      end else if (clear) begin
        f        <= '0;
        sat_flag <= 1'b0;
        count    <= '0;
      end
    end
  end

endmodule
